// File: rtl/cda_pkg.sv
// cda_pkg: definitions shared by the array-order checker.
//   state_e     - scan controller states (IDLE / ISSUE / DRAIN / DONE)
//   WORD_STRIDE - byte distance between consecutive array elements
package cda_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int WORD_STRIDE = 4;

endpackage

// File: rtl/sort_checker_order_cmp.sv
// order_cmp: combinational ordering check between two consecutive elements.
//   prev      - value of element i-1
//   curr      - value of element i
//   violation - 1 when the pair breaks the required order; equal values never
//               count as a violation
// SIGNED_CMP selects two's-complement vs unsigned comparison, DESCENDING
// selects non-increasing (1) vs non-decreasing (0) order.
module order_cmp #(
  parameter int DATA_WIDTH = 32,
  parameter bit SIGNED_CMP = 1'b1,
  parameter bit DESCENDING = 1'b0
) (
  input  logic [DATA_WIDTH-1:0] prev,
  input  logic [DATA_WIDTH-1:0] curr,
  output logic                  violation
);

  logic curr_lt_prev;
  logic curr_gt_prev;

  always_comb begin
    if (SIGNED_CMP) begin
      curr_lt_prev = $signed(curr) < $signed(prev);
      curr_gt_prev = $signed(curr) > $signed(prev);
    end else begin
      curr_lt_prev = curr < prev;
      curr_gt_prev = curr > prev;
    end
    violation = DESCENDING ? curr_gt_prev : curr_lt_prev;
  end

endmodule

// File: rtl/sort_checker.sv
// sort_checker: walks a word array through a synchronous read port (1-cycle
// read latency) and reports whether it is in order.
// Ports:
//   clk, reset      - rising-edge clock, asynchronous active-high reset
//   start           - begin a scan (only looked at while idle)
//   base_addr,count - byte address of element 0 and number of elements
//   mem_rd,mem_addr - read strobe and byte address
//   mem_rdata       - read data, valid the cycle after mem_rd
//   busy, done      - scan in progress / one-cycle end-of-scan pulse
//   sorted          - result of the last scan (0 until a scan completes)
//   fail_index, fail_prev, fail_curr - first out-of-order pair (i-1, i)
//   viol_count      - number of out-of-order pairs, saturating
//   dbg_state       - current controller state
//
// Handshake: there is no backpressure. Every cycle mem_rd is high the memory
// must return that word on mem_rdata exactly one cycle later; start is a
// single-cycle request accepted only while idle and ignored when busy.
module sort_checker
  import cda_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int CNT_WIDTH    = 16,
  parameter bit SIGNED_CMP   = 1'b1,
  parameter bit DESCENDING   = 1'b0,
  parameter bit STOP_ON_FAIL = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  count,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  sorted,
  output logic [CNT_WIDTH-1:0]  fail_index,
  output logic [DATA_WIDTH-1:0] fail_prev,
  output logic [DATA_WIDTH-1:0] fail_curr,
  output logic [CNT_WIDTH-1:0]  viol_count,
  output state_e                dbg_state
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;        // address of the next issue
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;          // latched element count
  logic [CNT_WIDTH-1:0]  iss_idx_q, iss_idx_d;  // index of the next issue
  logic [CNT_WIDTH-1:0]  ret_idx_q, ret_idx_d;  // index of the returning word
  logic                  rvalid_q, rvalid_d;    // mem_rdata is valid this cycle
  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic                  sorted_q, sorted_d;
  logic [CNT_WIDTH-1:0]  fail_index_q, fail_index_d;
  logic [DATA_WIDTH-1:0] fail_prev_q, fail_prev_d;
  logic [DATA_WIDTH-1:0] fail_curr_q, fail_curr_d;
  logic [CNT_WIDTH-1:0]  viol_count_q, viol_count_d;

  logic cmp_viol;
  logic hit;       // returning word is out of order with its predecessor
  logic stop_now;  // early termination takes effect this cycle

  order_cmp #(
    .DATA_WIDTH (DATA_WIDTH),
    .SIGNED_CMP (SIGNED_CMP),
    .DESCENDING (DESCENDING)
  ) u_cmp (
    .prev      (prev_q),
    .curr      (mem_rdata),
    .violation (cmp_viol)
  );

  // Element 0 only primes prev, so it can never be a violation.
  assign hit      = rvalid_q && (ret_idx_q != '0) && cmp_viol;
  assign stop_now = STOP_ON_FAIL && hit;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (count < CNT_WIDTH'(2)) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (stop_now) begin
          state_d = DONE;
        end else if (iss_idx_q == cnt_q - CNT_WIDTH'(1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (rvalid_q) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs. A violation seen while issuing suppresses the read that
  // would otherwise go out in the same cycle, so nothing is left in flight.
  always_comb begin
    mem_rd    = (state_q == ISSUE) && !stop_now;
    mem_addr  = mem_rd ? addr_q : '0;
    busy      = (state_q == ISSUE) || (state_q == DRAIN);
    done      = (state_q == DONE);
    dbg_state = state_q;
  end

  // Datapath next values.
  always_comb begin
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    iss_idx_d    = iss_idx_q;
    ret_idx_d    = ret_idx_q;
    rvalid_d     = mem_rd;
    prev_d       = prev_q;
    sorted_d     = sorted_q;
    fail_index_d = fail_index_q;
    fail_prev_d  = fail_prev_q;
    fail_curr_d  = fail_curr_q;
    viol_count_d = viol_count_q;

    if ((state_q == IDLE) && start) begin
      addr_d       = base_addr;
      cnt_d        = count;
      iss_idx_d    = '0;
      ret_idx_d    = '0;
      sorted_d     = 1'b0;
      fail_index_d = '0;
      fail_prev_d  = '0;
      fail_curr_d  = '0;
      viol_count_d = '0;
    end

    // Address arithmetic wraps modulo 2^ADDR_WIDTH by construction.
    if (mem_rd) begin
      addr_d    = addr_q + ADDR_WIDTH'(WORD_STRIDE);
      iss_idx_d = iss_idx_q + CNT_WIDTH'(1);
    end

    if (rvalid_q) begin
      prev_d    = mem_rdata;
      ret_idx_d = ret_idx_q + CNT_WIDTH'(1);
      if (hit) begin
        // The count never returns to zero once bumped, so zero marks "first".
        if (viol_count_q == '0) begin
          fail_index_d = ret_idx_q;
          fail_prev_d  = prev_q;
          fail_curr_d  = mem_rdata;
        end
        if (viol_count_q != '1) begin
          viol_count_d = viol_count_q + CNT_WIDTH'(1);
        end
      end
    end

    // Publish the verdict as DONE is entered so it is valid alongside done.
    if ((state_d == DONE) && (state_q != DONE)) begin
      sorted_d = (viol_count_d == '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q       <= '0;
      cnt_q        <= '0;
      iss_idx_q    <= '0;
      ret_idx_q    <= '0;
      rvalid_q     <= 1'b0;
      prev_q       <= '0;
      sorted_q     <= 1'b0;
      fail_index_q <= '0;
      fail_prev_q  <= '0;
      fail_curr_q  <= '0;
      viol_count_q <= '0;
    end else begin
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      iss_idx_q    <= iss_idx_d;
      ret_idx_q    <= ret_idx_d;
      rvalid_q     <= rvalid_d;
      prev_q       <= prev_d;
      sorted_q     <= sorted_d;
      fail_index_q <= fail_index_d;
      fail_prev_q  <= fail_prev_d;
      fail_curr_q  <= fail_curr_d;
      viol_count_q <= viol_count_d;
    end
  end

  assign sorted     = sorted_q;
  assign fail_index = fail_index_q;
  assign fail_prev  = fail_prev_q;
  assign fail_curr  = fail_curr_q;
  assign viol_count = viol_count_q;

endmodule

// File: tb/tb_sort_checker.sv
// Bench for sort_checker. Four instances cover the parameter corners:
//   0: signed, ascending, stop on fail (defaults)
//   1: signed, ascending, full scan
//   2: unsigned, ascending, stop on fail
//   3: signed, descending, stop on fail
// All share one word memory with a 1-cycle read latency.
module tb_sort_checker;

  localparam logic [3:0] SGN_P  = 4'b1011;
  localparam logic [3:0] DESC_P = 4'b1000;
  localparam logic [3:0] STOP_P = 4'b1101;

  typedef struct packed {
    logic        rd;
    logic [31:0] addr;
    logic        busy;
    logic        done;
  } cyc_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUTs and memory ----------------
  logic [3:0]        start_s = '0;
  logic [31:0]       base_s = '0;
  logic [15:0]       count_s = '0;
  logic [3:0]        mem_rd_w;
  logic [3:0][31:0]  mem_addr_w;
  logic [3:0][31:0]  rdata_w;
  logic [3:0]        busy_w, done_w, sorted_w;
  logic [3:0][15:0]  fidx_w, vcnt_w;
  logic [3:0][31:0]  fprev_w, fcurr_w;
  logic [3:0][1:0]   st_w;
  logic [31:0]       mem [0:1023];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    cda_pkg::state_e st;
    assign st_w[g] = st;

    sort_checker #(
      .SIGNED_CMP   (SGN_P[g]),
      .DESCENDING   (DESC_P[g]),
      .STOP_ON_FAIL (STOP_P[g])
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start_s[g]),
      .base_addr  (base_s),
      .count      (count_s),
      .mem_rd     (mem_rd_w[g]),
      .mem_addr   (mem_addr_w[g]),
      .mem_rdata  (rdata_w[g]),
      .busy       (busy_w[g]),
      .done       (done_w[g]),
      .sorted     (sorted_w[g]),
      .fail_index (fidx_w[g]),
      .fail_prev  (fprev_w[g]),
      .fail_curr  (fcurr_w[g]),
      .viol_count (vcnt_w[g]),
      .dbg_state  (st)
    );

    // Word not requested last cycle reads back as garbage.
    always @(posedge clk) begin
      rdata_w[g] <= mem_rd_w[g] ? mem[mem_addr_w[g][11:2]] : 32'hDEAD_BEEF;
    end
  end

  // ---------------- scoreboard state ----------------
  int   checks = 0;
  int   errors = 0;
  cyc_t exp_q[$];
  int   cur = 0;
  logic armed = 1'b0;
  logic        res_sorted;
  logic [15:0] res_fidx, res_viol;
  logic [31:0] res_fprev, res_fcurr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    cyc_t e;
    if (armed && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("mem_rd", 32'(mem_rd_w[cur]), 32'(e.rd));
      if (e.rd) chk("mem_addr", mem_addr_w[cur], e.addr);
      chk("busy", 32'(busy_w[cur]), 32'(e.busy));
      chk("done", 32'(done_w[cur]), 32'(e.done));
      if (e.done) begin
        chk("sorted", 32'(sorted_w[cur]), 32'(res_sorted));
        chk("fail_index", 32'(fidx_w[cur]), 32'(res_fidx));
        chk("fail_prev", fprev_w[cur], res_fprev);
        chk("fail_curr", fcurr_w[cur], res_fcurr);
        chk("viol_count", 32'(vcnt_w[cur]), 32'(res_viol));
      end
    end
  end

  // ---------------- model + driver ----------------
  // Derives the expected per-cycle behaviour and final results directly
  // from the array contents, then launches the scan.
  task automatic run_scan(input int inst, input logic [31:0] base, input logic [31:0] vals[$]);
    int          n;
    int          stop_k;
    int          last;
    logic        bad;
    logic [31:0] a, p, c;
    n = vals.size();
    for (int i = 0; i < n; i++) begin
      a = base + 32'(4 * i);
      mem[a[11:2]] = vals[i];
    end

    res_viol = '0; res_fidx = '0; res_fprev = '0; res_fcurr = '0;
    stop_k = -1;
    for (int i = 1; i < n; i++) begin
      p = vals[i-1];
      c = vals[i];
      if (DESC_P[inst]) bad = SGN_P[inst] ? ($signed(c) > $signed(p)) : (c > p);
      else              bad = SGN_P[inst] ? ($signed(c) < $signed(p)) : (c < p);
      if (bad) begin
        if (res_viol == 0) begin
          res_fidx = 16'(i); res_fprev = p; res_fcurr = c;
        end
        res_viol++;
        if (STOP_P[inst]) begin
          stop_k = i;
          break;
        end
      end
    end
    res_sorted = (res_viol == 0);

    exp_q.delete();
    if (n < 2) begin
      exp_q.push_back('{rd: 1'b0, addr: 32'h0, busy: 1'b0, done: 1'b1});
    end else begin
      last = (stop_k >= 0) ? stop_k : n - 1;
      for (int cy = 1; cy <= last + 1; cy++)
        exp_q.push_back('{rd: 1'b1, addr: base + 32'(4 * (cy - 1)), busy: 1'b1, done: 1'b0});
      exp_q.push_back('{rd: 1'b0, addr: 32'h0, busy: 1'b1, done: 1'b0});
      exp_q.push_back('{rd: 1'b0, addr: 32'h0, busy: 1'b0, done: 1'b1});
    end

    @(negedge clk);
    cur = inst;
    base_s = base;
    count_s = 16'(n);
    start_s[inst] = 1'b1;
    @(posedge clk);
    #1 start_s[inst] = 1'b0;
    armed = 1'b1;
    for (int t = 0; t < 300 && exp_q.size() > 0; t++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL timeout: %0d expected cycles never observed", exp_q.size());
      exp_q.delete();
    end
    armed = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", 32'(done_w[inst]), 32'h0);
    chk("result_hold", 32'(sorted_w[inst]), 32'(res_sorted));
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] q[$];
  logic [31:0] uns[$];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    uns = '{55, 88, 0, 22, 77, 11, 99, 33, 110, 66, 121, 44};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_rd", 32'(mem_rd_w[0]), 32'h0);
    chk("rst_mem_addr", mem_addr_w[0], 32'h0);
    chk("rst_sorted", 32'(sorted_w[0]), 32'h0);
    chk("rst_viol", 32'(vcnt_w[0]), 32'h0);
    chk("rst_state", 32'(st_w[0]), 32'h0);
    reset = 1'b0;

    // Sorted scan, 12 words at 512.
    q = {};
    for (int i = 0; i < 12; i++) q.push_back(32'(11 * i));
    run_scan(0, 32'd512, q);
    chk("lit_sorted", 32'(sorted_w[0]), 32'h1);

    // Unsorted, stop at first violation.
    run_scan(0, 32'd512, uns);
    chk("lit_stop_fidx", 32'(fidx_w[0]), 32'd2);
    chk("lit_stop_fprev", fprev_w[0], 32'd88);
    chk("lit_stop_fcurr", fcurr_w[0], 32'd0);
    chk("lit_stop_viol", 32'(vcnt_w[0]), 32'd1);

    // Unsorted, full scan.
    run_scan(1, 32'd512, uns);
    chk("model_full_viol", 32'(res_viol), 32'd5);
    chk("lit_full_viol", 32'(vcnt_w[1]), 32'd5);
    chk("lit_full_fidx", 32'(fidx_w[1]), 32'd2);

    // Signedness: -1, 1.
    q = '{32'hFFFF_FFFF, 32'h1};
    run_scan(0, 32'd64, q);
    chk("lit_signed_sorted", 32'(sorted_w[0]), 32'h1);
    run_scan(2, 32'd64, q);
    chk("lit_unsigned_sorted", 32'(sorted_w[2]), 32'h0);

    // Descending with equal neighbours.
    q = '{32'd5, 32'd5, 32'd3};
    run_scan(3, 32'd128, q);
    chk("lit_desc_sorted", 32'(sorted_w[3]), 32'h1);

    // Address wrap past 2^32.
    q = '{32'd1, 32'd2, 32'd3, 32'd4};
    run_scan(0, 32'hFFFF_FFF8, q);
    chk("model_wrap_sorted", 32'(res_sorted), 32'h1);

    // Degenerate counts.
    q = {};
    run_scan(0, 32'd512, q);
    q = '{32'd7};
    run_scan(0, 32'd512, q);
    chk("lit_cnt1_sorted", 32'(sorted_w[0]), 32'h1);

    // Reset in cycle 4 of a 12-element scan.
    q = {};
    for (int i = 0; i < 12; i++) q.push_back(32'(11 * i));
    for (int i = 0; i < 12; i++) mem[(512 >> 2) + i] = q[i];
    @(negedge clk);
    cur = 0; base_s = 32'd512; count_s = 16'd12; start_s[0] = 1'b1;
    @(posedge clk);
    #1 start_s[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy_w[0]), 32'h1);
    reset = 1'b1;
    #1;
    chk("arst_mem_rd", 32'(mem_rd_w[0]), 32'h0);
    chk("arst_mem_addr", mem_addr_w[0], 32'h0);
    chk("arst_busy", 32'(busy_w[0]), 32'h0);
    chk("arst_done", 32'(done_w[0]), 32'h0);
    chk("arst_sorted", 32'(sorted_w[0]), 32'h0);
    chk("arst_fidx", 32'(fidx_w[0]), 32'h0);
    chk("arst_fprev", fprev_w[0], 32'h0);
    chk("arst_fcurr", fcurr_w[0], 32'h0);
    chk("arst_viol", 32'(vcnt_w[0]), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_done", 32'(done_w[0]), 32'h0);
    end
    run_scan(0, 32'd512, q);
    chk("lit_after_rst_sorted", 32'(sorted_w[0]), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
